seg7_scan_decoder: RTL

- Reads the multiplexed 8-digit 7-segment bus (anode select plus segment byte) and recovers the eight hex nibbles and decimal points being displayed.
- Used for on-board loopback self-test of the display path and for monitoring whatever the display logic drives.
- Segment byte encoding: bit0=a … bit6=g, bit7=dp, active-high (e.g. "0" = 0x3F).
- Output is one 32-bit frame per complete scan, delivered with a valid/ready handshake.

---
 rtl/seg7_scan_decoder_if.sv | 25 ++
 rtl/seg7_scan_decoder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder_if.sv
// Bundle of the display-bus tap and the frame output handshake.
// The master side is the environment that drives the display bus and
// consumes frames. The slave side is the decoder.
interface seg7_scan_decoder_if;
    logic [7:0]  AN_I;
    logic [7:0]  SEG_I;
    logic        RDY_I;
    logic        CLR_I;
    logic [31:0] DATA_O;
    logic [7:0]  DP_O;
    logic [7:0]  BAD_O;
    logic        VLD_O;
    logic        ERR_O;
    logic        OVF_O;

    modport master (
        output AN_I, SEG_I, RDY_I, CLR_I,
        input  DATA_O, DP_O, BAD_O, VLD_O, ERR_O, OVF_O
    );

    modport slave (
        input  AN_I, SEG_I, RDY_I, CLR_I,
        output DATA_O, DP_O, BAD_O, VLD_O, ERR_O, OVF_O
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers the eight hex digits and decimal points from a multiplexed
// 7-segment bus. A digit is captured once its anode/segment pair has been
// steady for STABLE_CYC samples. One frame is emitted each time all eight
// digits have been seen.
module seg7_scan_decoder #(
    parameter int STABLE_CYC = 4
) (
    input logic               CLK,
    input logic               RST,
    seg7_scan_decoder_if.slave bus
);

    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC);

    logic [7:0]    s_an_reg;
    logic [7:0]    s_seg_reg;
    logic [CW-1:0] cnt_reg;
    logic          armed_reg;
    logic [7:0]    seen_reg;
    logic [31:0]   nib_reg;
    logic [7:0]    dp_reg;
    logic [7:0]    bad_reg;
    logic [31:0]   data_reg;
    logic [7:0]    dp_out_reg;
    logic [7:0]    bad_out_reg;
    logic          vld_reg;
    logic          err_reg;
    logic          ovf_reg;

    logic          same_sample;
    logic [7:0]    an_sel;
    logic          one_digit;
    logic          capture;
    logic [7:0]    cap_en;
    logic [3:0]    dec_nib;
    logic          dec_ok;
    logic          frame_load;

    assign same_sample = (bus.AN_I == s_an_reg) && (bus.SEG_I == s_seg_reg);

    // Anodes are active-low, so the inverted sample is one-hot for a real digit.
    assign an_sel    = ~s_an_reg;
    assign one_digit = (an_sel != 8'h00) && ((an_sel & (an_sel - 8'h01)) == 8'h00);
    assign capture   = (cnt_reg == CNT_MAX) && armed_reg && one_digit;
    assign frame_load = (seen_reg == 8'hFF);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_cap
            assign cap_en[gi] = capture && an_sel[gi];
        end
    endgenerate

    // Segment pattern to nibble. Anything not in the hex table is flagged bad.
    always_comb begin
        dec_nib = 4'h0;
        dec_ok  = 1'b1;
        case (s_seg_reg[6:0])
            7'h3F: dec_nib = 4'h0;
            7'h06: dec_nib = 4'h1;
            7'h5B: dec_nib = 4'h2;
            7'h4F: dec_nib = 4'h3;
            7'h66: dec_nib = 4'h4;
            7'h6D: dec_nib = 4'h5;
            7'h7D: dec_nib = 4'h6;
            7'h27: dec_nib = 4'h7;
            7'h7F: dec_nib = 4'h8;
            7'h67: dec_nib = 4'h9;
            7'h77: dec_nib = 4'hA;
            7'h7C: dec_nib = 4'hB;
            7'h39: dec_nib = 4'hC;
            7'h5E: dec_nib = 4'hD;
            7'h79: dec_nib = 4'hE;
            7'h71: dec_nib = 4'hF;
            default: dec_ok = 1'b0;
        endcase
    end

    // Input sampling, stability counting and one-shot capture arming.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s_an_reg  <= 8'h00;
            s_seg_reg <= 8'h00;
            cnt_reg   <= '0;
            armed_reg <= 1'b0;
        end else begin
            s_an_reg  <= bus.AN_I;
            s_seg_reg <= bus.SEG_I;
            if (same_sample) begin
                if (cnt_reg != CNT_MAX)
                    cnt_reg <= cnt_reg + CW'(1);
                if (capture)
                    armed_reg <= 1'b0;
            end else begin
                cnt_reg   <= CW'(1);
                armed_reg <= 1'b1;
            end
        end
    end

    // Per-digit stores; a later capture of the same digit overwrites the earlier one.
    always_ff @(posedge CLK) begin
        if (RST) begin
            nib_reg  <= 32'h0;
            dp_reg   <= 8'h00;
            bad_reg  <= 8'h00;
            seen_reg <= 8'h00;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (cap_en[i]) begin
                    nib_reg[4*i +: 4] <= dec_nib;
                    dp_reg[i]         <= s_seg_reg[7];
                    bad_reg[i]        <= ~dec_ok;
                end
            end
            seen_reg <= frame_load ? cap_en : (seen_reg | cap_en);
        end
    end

    // Frame output, handshake and sticky status flags (set beats clear).
    always_ff @(posedge CLK) begin
        if (RST) begin
            data_reg    <= 32'h0;
            dp_out_reg  <= 8'h00;
            bad_out_reg <= 8'h00;
            vld_reg     <= 1'b0;
            err_reg     <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            if (frame_load) begin
                data_reg    <= nib_reg;
                dp_out_reg  <= dp_reg;
                bad_out_reg <= bad_reg;
                vld_reg     <= 1'b1;
            end else if (vld_reg && bus.RDY_I) begin
                vld_reg <= 1'b0;
            end

            if (capture && !dec_ok)
                err_reg <= 1'b1;
            else if (bus.CLR_I)
                err_reg <= 1'b0;

            if (frame_load && vld_reg && !bus.RDY_I)
                ovf_reg <= 1'b1;
            else if (bus.CLR_I)
                ovf_reg <= 1'b0;
        end
    end

    assign bus.DATA_O = data_reg;
    assign bus.DP_O   = dp_out_reg;
    assign bus.BAD_O  = bad_out_reg;
    assign bus.VLD_O  = vld_reg;
    assign bus.ERR_O  = err_reg;
    assign bus.OVF_O  = ovf_reg;

endmodule
